// File: rtl/des_pkg.sv
// DES S-box layer constants: the eight FIPS 46-3 substitution tables and the P permutation.
package des_pkg;

   localparam int unsigned SBOX_IN_W  = 6;
   localparam int unsigned SBOX_OUT_W = 4;
   localparam int unsigned DES_NUM_SBOX = 8;
   localparam int unsigned P_W = DES_NUM_SBOX * SBOX_OUT_W;

   // Entry e = row*16 + col; entry 0 sits at the MSB end of each 256-bit literal.
   typedef logic [0:63][SBOX_OUT_W-1:0] sbox_tbl_t;

   localparam sbox_tbl_t SBOX_TBL [DES_NUM_SBOX] = '{
      {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
      {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
      {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
      {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
      {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
      {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
      {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
      {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
   };

   // Output bit i (1 = MSB) takes input bit P_TBL[i-1] (1 = MSB).
   localparam logic [5:0] P_TBL [P_W] = '{
      6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
      6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
      6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
      6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
   };

   // Row is the outer bit pair {b5,b0}, column the inner nibble b4..b1.
   function automatic logic [5:0] sbox_index(input logic [SBOX_IN_W-1:0] din);
      return {din[5], din[0], din[4:1]};
   endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// One combinational DES S-box lookup, selecting table S(SBOX_IDX).
module des_sbox_lut
   import des_pkg::*;
#(
   parameter int unsigned SBOX_IDX = 1
) (
   input  logic [SBOX_IN_W-1:0]  din,
   output logic [SBOX_OUT_W-1:0] dout_c
);

   if (SBOX_IDX < 1 || SBOX_IDX > DES_NUM_SBOX) begin : g_bad_idx
      $error("des_sbox_lut: SBOX_IDX must be 1..8");
   end

   localparam logic [2:0] TBL_SEL = 3'(SBOX_IDX - 1);

   assign dout_c = SBOX_TBL[TBL_SEL][sbox_index(din)];

endmodule

// File: rtl/des_sbox_layer.sv
// Parallel DES S-box layer with an elastic valid/ready pipeline and optional P permutation.
module des_sbox_layer
   import des_pkg::*;
#(
   parameter int unsigned NUM_SBOX    = 8,
   parameter int unsigned PIPE_STAGES = 2,
   parameter int unsigned APPLY_P     = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [SBOX_IN_W*NUM_SBOX-1:0]  in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [SBOX_OUT_W*NUM_SBOX-1:0] out_data,
   output logic                           busy
);

   localparam int unsigned IN_W  = SBOX_IN_W * NUM_SBOX;
   localparam int unsigned OUT_W = SBOX_OUT_W * NUM_SBOX;

   if (NUM_SBOX < 1 || NUM_SBOX > DES_NUM_SBOX) begin : g_bad_num
      $error("des_sbox_layer: NUM_SBOX must be 1..8");
   end
   if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe
      $error("des_sbox_layer: PIPE_STAGES must be 1..4");
   end
   if (APPLY_P != 0 && NUM_SBOX != DES_NUM_SBOX) begin : g_bad_p
      $error("des_sbox_layer: APPLY_P requires NUM_SBOX == 8");
   end

   logic [OUT_W-1:0] lut_c;

   for (genvar k = 0; k < int'(NUM_SBOX); k++) begin : g_lut
      des_sbox_lut #(
         .SBOX_IDX(k + 1)
      ) u_lut (
         .din    (in_data[IN_W-1-SBOX_IN_W*k -: SBOX_IN_W]),
         .dout_c (lut_c[OUT_W-1-SBOX_OUT_W*k -: SBOX_OUT_W])
      );
   end

   logic [PIPE_STAGES-1:0] v_q;
   logic [OUT_W-1:0]       d_q     [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] adv_c;
   logic [PIPE_STAGES:0]   ld_c;
   logic [PIPE_STAGES-1:0] src_v_c;
   logic [OUT_W-1:0]       src_d_c [PIPE_STAGES];

   // Ready ripples back from the output: a stage may load when empty or draining this cycle.
   always_comb begin
      adv_c = '0;
      ld_c  = '0;
      ld_c[PIPE_STAGES] = out_ready;
      for (int i = int'(PIPE_STAGES) - 1; i >= 0; i--) begin
         adv_c[i] = v_q[i] && ld_c[i+1];
         ld_c[i]  = !v_q[i] || adv_c[i];
      end
   end

   always_comb begin
      src_v_c    = '0;
      src_v_c[0] = in_valid;
      for (int i = 0; i < int'(PIPE_STAGES); i++) begin
         src_d_c[i] = lut_c;
      end
      for (int i = 1; i < int'(PIPE_STAGES); i++) begin
         src_v_c[i] = v_q[i-1];
         src_d_c[i] = d_q[i-1];
      end
   end

   // Data only moves with a valid word so bubbles never disturb held results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         for (int i = 0; i < int'(PIPE_STAGES); i++) begin
            d_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(PIPE_STAGES); i++) begin
            if (ld_c[i]) begin
               v_q[i] <= src_v_c[i];
               if (src_v_c[i]) begin
                  d_q[i] <= src_d_c[i];
               end
            end
         end
      end
   end

   assign in_ready  = ld_c[0];
   assign out_valid = v_q[PIPE_STAGES-1];
   assign busy      = |v_q;

   logic [OUT_W-1:0] fin;
   assign fin = d_q[PIPE_STAGES-1];

   if (APPLY_P != 0) begin : g_perm
      for (genvar j = 0; j < int'(P_W); j++) begin : g_bit
         localparam int unsigned SRC = P_W - int'(P_TBL[j]);
         assign out_data[OUT_W-1-j] = fin[SRC];
      end
   end else begin : g_noperm
      assign out_data = fin;
   end

endmodule

// File: tb/tb_des_sbox_layer.sv
// Directed bench for des_sbox_layer across several parameter sets sharing one clock and reset.
module tb_des_sbox_layer;
   import des_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        m_iv, m_or, m_ir, m_ov, m_busy;
   logic [47:0] m_id;
   logic [31:0] m_od;
   logic        p_ir, p_ov, p_busy;
   logic [31:0] p_od;
   logic        n1_ir, n1_ov, n1_busy;
   logic [3:0]  n1_od;
   logic        n6_ir, n6_ov, n6_busy;
   logic [23:0] n6_od;
   logic        b_iv, b_or, b_ir, b_ov, b_busy;
   logic [47:0] b_id;
   logic [31:0] b_od;

   des_sbox_layer #(.NUM_SBOX(8), .PIPE_STAGES(2), .APPLY_P(0)) u_m (
      .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir), .in_data(m_id),
      .out_valid(m_ov), .out_ready(m_or), .out_data(m_od), .busy(m_busy));

   des_sbox_layer #(.NUM_SBOX(8), .PIPE_STAGES(2), .APPLY_P(1)) u_p (
      .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(p_ir), .in_data(m_id),
      .out_valid(p_ov), .out_ready(m_or), .out_data(p_od), .busy(p_busy));

   des_sbox_layer #(.NUM_SBOX(1), .PIPE_STAGES(1), .APPLY_P(0)) u_n1 (
      .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(n1_ir), .in_data(m_id[47:42]),
      .out_valid(n1_ov), .out_ready(m_or), .out_data(n1_od), .busy(n1_busy));

   des_sbox_layer #(.NUM_SBOX(6), .PIPE_STAGES(2), .APPLY_P(0)) u_n6 (
      .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(n6_ir), .in_data(m_id[47:12]),
      .out_valid(n6_ov), .out_ready(m_or), .out_data(n6_od), .busy(n6_busy));

   des_sbox_layer #(.NUM_SBOX(8), .PIPE_STAGES(3), .APPLY_P(0)) u_bp (
      .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
      .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .busy(b_busy));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected 8-box output built straight from the FIPS row/column rule.
   function automatic logic [31:0] sbox_model(input logic [47:0] x);
      logic [31:0] r;
      logic [5:0]  b;
      int          row, col;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         b   = x[47-6*k -: 6];
         row = 2 * int'(b[5]) + int'(b[0]);
         col = int'(b[4:1]);
         r[31-4*k -: 4] = SBOX_TBL[3'(k)][6'(row*16 + col)];
      end
      return r;
   endfunction

   localparam logic [47:0] W0 = 48'h0;
   localparam logic [47:0] W1 = {6'b011011, 24'h0, 6'b000001, 12'h0};

   logic [31:0] q [$];
   logic [47:0] w;
   logic [47:0] bw [5];
   int          acc;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      m_iv = 1'b0; m_or = 1'b1; m_id = '0;
      b_iv = 1'b0; b_or = 1'b0; b_id = '0;
      #2;
      chk("rst_ov", m_ov, 0);
      chk("rst_busy", m_busy | p_busy | n1_busy | n6_busy | b_busy, 0);
      chk("rst_rdy", {m_ir, p_ir, n1_ir, n6_ir, b_ir}, 5'b11111);
      chk("rst_data", m_od, 0);
      chk("rst_pdata", p_od, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_rst_rdy", m_ir, 1);

      // Zero word and a row/column probe word through every configuration.
      m_iv = 1'b1; m_id = W0;
      tick();
      chk("n1_lat_ov", n1_ov, 1);
      chk("n1_s1_zero", n1_od, 4'hE);
      chk("m_lat_ov_early", m_ov, 0);
      m_id = W1;
      tick();
      chk("m_lat_ov", m_ov, 1);
      chk("m_zero", m_od, 32'hEFA72C4D);
      chk("p_zero", p_od, 32'hD8D8DBBC);
      chk("n6_zero", n6_od, 24'hEFA72C);
      chk("n1_s1_1b", n1_od, 4'h5);
      m_iv = 1'b0;
      tick();
      chk("m_w1", m_od, 32'h5FA72A4D);
      chk("n6_w1", n6_od, 24'h5FA72A);
      chk("n1_idle", n1_ov, 0);
      tick();
      chk("m_idle_busy", m_busy, 0);
      chk("m_idle_ov", m_ov, 0);

      // Every input value through every box, one word per cycle.
      for (int i = 0; i < 64; i++) begin
         for (int k = 0; k < 8; k++) w[47-6*k -: 6] = 6'(i + 7*k);
         m_id = w; m_iv = 1'b1;
         #1;
         chk("sweep_rdy", m_ir, 1);
         q.push_back(sbox_model(w));
         if (m_ov) begin
            if (q.size() > 1) chk("sweep_data", m_od, q.pop_front());
            else chk("sweep_extra", m_ov, 0);
         end
         tick();
      end
      m_iv = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (m_ov) begin
            if (q.size() > 0) chk("sweep_data", m_od, q.pop_front());
            else chk("sweep_extra", m_ov, 0);
         end
         tick();
      end
      chk("sweep_drain", q.size(), 0);
      q.delete();

      // Backpressure on a three-stage pipe.
      bw[0] = 48'h0; bw[1] = 48'hFFFF_FFFF_FFFF; bw[2] = 48'h0123_4567_89AB;
      bw[3] = W1;    bw[4] = 48'h0;
      acc = 0; b_or = 1'b0;
      repeat (5) begin
         b_id = bw[acc]; b_iv = 1'b1;
         #1;
         if (b_ir) begin
            q.push_back(sbox_model(bw[acc]));
            acc++;
         end
         tick();
      end
      chk("bp_accepted", acc, 3);
      chk("bp_full_rdy", b_ir, 0);
      chk("bp_full_ov", b_ov, 1);
      chk("bp_head", b_od, q[0]);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("bp_hold", b_od, q[0]);
         chk("bp_hold_rdy", b_ir, 0);
      end
      b_or = 1'b1;
      for (int c = 0; c < 12 && !(acc == 4 && q.size() == 0); c++) begin
         b_id = bw[acc]; b_iv = (acc < 4);
         #1;
         if (b_iv && b_ir) begin
            q.push_back(sbox_model(bw[acc]));
            acc++;
         end
         if (b_ov) begin
            if (q.size() > 0) chk("bp_order", b_od, q.pop_front());
            else chk("bp_extra", b_ov, 0);
         end
         tick();
      end
      b_iv = 1'b0;
      chk("bp_all_in", acc, 4);
      chk("bp_all_out", q.size(), 0);
      chk("bp_empty", b_busy, 0);

      // Reset with two words held in flight.
      m_or = 1'b0; m_iv = 1'b1; m_id = W0;
      tick();
      m_id = W1;
      tick();
      m_iv = 1'b0;
      chk("mid_pre_ov", m_ov, 1);
      chk("mid_pre_rdy", m_ir, 0);
      #2 rst = 1'b1;
      #1;
      chk("mid_ov", m_ov, 0);
      chk("mid_busy", m_busy, 0);
      chk("mid_rdy", m_ir, 1);
      chk("mid_data", m_od, 0);
      #1 rst = 1'b0;
      m_or = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("mid_no_emit", m_ov, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
